// File: rtl/nibble_serial_adder_sequencer.sv
// Drives one shared 4-bit ripple adder one nibble per clock to add or subtract WIDTH-bit words.
// Ports: clk/rst_n, start/sub/op_a/op_b in, busy/done/result/flags out, add_* adder-side bus.
`timescale 1ns/1ps
module nibble_serial_adder_sequencer #(
    parameter int WIDTH   = 8,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        add_a       = 4'h0;
        add_b       = 4'h0;
        add_cin     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract is A + ~B + 1: invert B here, seed the carry with 1.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        add_a = a_q[4*i +: 4];
                        add_b = b_q[4*i +: 4];
                        acc_d[4*i +: 4] = add_s;
                    end
                end
                add_cin = carry_q;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    // acc_d already holds the MSB nibble from this pass.
                    state_d     = DONE;
                    result_d    = acc_d;
                    carry_out_d = add_cout;
                    overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (add_s[3] != a_q[WIDTH-1]);
                    zero_d      = (acc_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder_sequencer.sv
// Scoreboard bench: 8- and 16-bit sequencers, each with a behavioural 4-bit adder.
// Ports: none.
`timescale 1ns/1ps
module tb_nibble_serial_adder_sequencer;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cmp = 0;
    int bad = 0;

    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  op_a8 = '0, op_b8 = '0;
    logic        busy8, done8, carry8, ovf8, zero8;
    logic [7:0]  result8;
    logic [3:0]  add_a8, add_b8, add_s8;
    logic        add_cin8, add_cout8;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] op_a16 = '0, op_b16 = '0;
    logic        busy16, done16, carry16, ovf16, zero16;
    logic [15:0] result16;
    logic [3:0]  add_a16, add_b16, add_s16;
    logic        add_cin16, add_cout16;

    assign {add_cout8, add_s8}   = 5'(add_a8) + 5'(add_b8) + 5'(add_cin8);
    assign {add_cout16, add_s16} = 5'(add_a16) + 5'(add_b16) + 5'(add_cin16);

    nibble_serial_adder_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
        .op_a(op_a8), .op_b(op_b8), .busy(busy8), .done(done8),
        .result(result8), .carry_out(carry8), .overflow(ovf8), .zero(zero8),
        .add_a(add_a8), .add_b(add_b8), .add_cin(add_cin8),
        .add_s(add_s8), .add_cout(add_cout8)
    );

    nibble_serial_adder_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16),
        .op_a(op_a16), .op_b(op_b16), .busy(busy16), .done(done16),
        .result(result16), .carry_out(carry16), .overflow(ovf16), .zero(zero16),
        .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
        .add_s(add_s16), .add_cout(add_cout16)
    );

    exp_t q8[$];
    exp_t q16[$];
    logic [15:0] last8 = '0;
    logic [15:0] last16 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input int unsigned a,
                                   input int unsigned b, input logic s);
        exp_t e;
        longint m, sa, sb, sr, ur;
        m  = longint'(1) << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sr = s ? sa - sb : sa + sb;
        ur = s ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
        e.c = s ? (a >= b) : (ur >= m);
        ur  = ((ur % m) + m) % m;
        e.r = 16'(ur);
        e.v = (sr < -(m / 2)) || (sr >= m / 2);
        e.z = (ur == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'(done8), 32'd0);
            end else begin
                e = q8.pop_front();
                check("result8", 32'(result8), 32'(e.r));
                check("carry8", 32'(carry8), 32'(e.c));
                check("ovf8", 32'(ovf8), 32'(e.v));
                check("zero8", 32'(zero8), 32'(e.z));
                last8 = e.r;
            end
        end else begin
            check("hold8", 32'(result8), 32'(last8));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last16 = '0;
        end else if (done16) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 32'(done16), 32'd0);
            end else begin
                e = q16.pop_front();
                check("result16", 32'(result16), 32'(e.r));
                check("carry16", 32'(carry16), 32'(e.c));
                check("ovf16", 32'(ovf16), 32'(e.v));
                check("zero16", 32'(zero16), 32'(e.z));
                last16 = e.r;
            end
        end else begin
            check("hold16", 32'(result16), 32'(last16));
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic inject);
        int n;
        op_a8 = a; op_b8 = b; sub8 = s; start8 = 1'b1;
        q8.push_back(model(8, a, b, s));
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && busy8; i++) begin
            if (a == 8'h85 && b == 8'h7B && !s && i < 2)
                check("adder_port8", {23'd0, add_a8, add_b8, add_cin8},
                      (i == 0) ? {23'd0, 4'h5, 4'hB, 1'b0}
                               : {23'd0, 4'h8, 4'h7, 1'b1});
            if (inject) begin
                start8 = (i == 0);
                op_a8  = 8'hFF; op_b8 = 8'hFF; sub8 = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start8 = 1'b0;
        check("busy_cycles8", 32'(n), 32'd3);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n;
        op_a16 = a; op_b16 = b; sub16 = s; start16 = 1'b1;
        q16.push_back(model(16, a, b, s));
        @(posedge clk); #1;
        start16 = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && busy16; i++) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_cycles16", 32'(n), 32'd5);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset8", {busy8, done8, result8, carry8, ovf8, zero8,
                         add_a8, add_b8, add_cin8}, 32'd0);
        check("reset16", {busy16, done16, result16, carry16, ovf16, zero16},
              32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run8(8'h85, 8'h7B, 1'b0, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 1'b0);
        run8(8'h10, 8'h01, 1'b1, 1'b0);
        run8(8'h00, 8'h01, 1'b1, 1'b0);
        run8(8'h80, 8'h01, 1'b1, 1'b0);
        run8(8'h23, 8'h45, 1'b0, 1'b1);

        // Abort 0x12+0x34 between its two RUN edges.
        op_a8 = 8'h12; op_b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort8", {busy8, done8, result8, carry8, ovf8, zero8,
                         add_a8, add_b8, add_cin8}, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run8(8'h12, 8'h34, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

        run16(16'hFFFF, 16'h0001, 1'b0);
        run16(16'h8000, 16'h0001, 1'b1);
        for (int k = 0; k < 12; k++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));

        repeat (3) @(posedge clk);
        #1;
        check("pending8", 32'(q8.size()), 32'd0);
        check("pending16", 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
